// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// one-cycle bubble insertion and a saturating stall-cycle counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [7:0]        Ctrl_i,
   input  logic              Flush_i,
   input  logic [DATA_W-1:0] RSdata_i,
   input  logic [DATA_W-1:0] RTdata_i,
   input  logic [DATA_W-1:0] Imm_i,
   input  logic [4:0]        RSaddr_i,
   input  logic [4:0]        RTaddr_i,
   input  logic [4:0]        RDaddr_i,
   output logic              ALUSrc_o,
   output logic [1:0]        ALUOp_o,
   output logic              RegDst_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic              MemtoReg_o,
   output logic              RegWrite_o,
   output logic [DATA_W-1:0] RSdata_o,
   output logic [DATA_W-1:0] RTdata_o,
   output logic [DATA_W-1:0] Imm_o,
   output logic [4:0]        RSaddr_o,
   output logic [4:0]        RTaddr_o,
   output logic [4:0]        RDaddr_o,
   output logic              Valid_o,
   output logic              Stall_o,
   output logic [CNT_W-1:0]  StallCnt_o
);
   logic [7:0]        ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
   logic [4:0]        rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hz, load;
   always_comb begin
      // A load writing $0 never creates a real dependency.
      hz        = valid_q & ctrl_q[3] & (|rt_addr_q) &
                  ((rt_addr_q == RSaddr_i) | (rt_addr_q == RTaddr_i));
      load      = ~Flush_i & ~hz;
      ctrl_d    = load ? Ctrl_i : 8'd0;
      valid_d   = load;
      rs_data_d = load ? RSdata_i : rs_data_q;
      rt_data_d = load ? RTdata_i : rt_data_q;
      imm_d     = load ? Imm_i    : imm_q;
      rs_addr_d = load ? RSaddr_i : rs_addr_q;
      rt_addr_d = load ? RTaddr_i : rt_addr_q;
      rd_addr_d = load ? RDaddr_i : rd_addr_q;
      cnt_d     = (hz & ~Flush_i & (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_addr_q <= '0;
         cnt_q     <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         rs_addr_q <= rs_addr_d;
         rt_addr_q <= rt_addr_d;
         rd_addr_q <= rd_addr_d;
         cnt_q     <= cnt_d;
      end
   end
   assign ALUSrc_o   = ctrl_q[7];
   assign ALUOp_o    = ctrl_q[6:5];
   assign RegDst_o   = ctrl_q[4];
   assign MemRead_o  = ctrl_q[3];
   assign MemWrite_o = ctrl_q[2];
   assign MemtoReg_o = ctrl_q[1];
   assign RegWrite_o = ctrl_q[0];
   assign RSdata_o   = rs_data_q;
   assign RTdata_o   = rt_data_q;
   assign Imm_o      = imm_q;
   assign RSaddr_o   = rs_addr_q;
   assign RTaddr_o   = rt_addr_q;
   assign RDaddr_o   = rd_addr_q;
   assign Valid_o    = valid_q;
   assign Stall_o    = hz & ~Flush_i;
   assign StallCnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors with a scoreboard queue; a second
// instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;
   typedef struct {
      logic [7:0]  ctrl;
      logic        flush;
      logic [31:0] rs, rt, imm;
      logic [4:0]  rsa, rta, rda;
      logic        exp_stall;
      logic        exp_valid;
      logic [15:0] exp_cnt;
   } vec_t;
   typedef struct {
      logic [7:0]   ctrl;
      logic         valid;
      logic [110:0] data;
      logic [15:0]  cnt;
   } out_t;

   logic clk = 1'b0, rst_i = 1'b0;
   logic [7:0] Ctrl_i = '0;
   logic Flush_i = 1'b0;
   logic [31:0] RSdata_i = '0, RTdata_i = '0, Imm_i = '0;
   logic [4:0] RSaddr_i = '0, RTaddr_i = '0, RDaddr_i = '0;
   logic a_alusrc, a_regdst, a_mr, a_mw, a_m2r, a_rw, a_valid, a_stall;
   logic [1:0] a_aluop;
   logic [31:0] a_rs, a_rt, a_imm;
   logic [4:0] a_rsa, a_rta, a_rda;
   logic [15:0] a_cnt;
   logic b_alusrc, b_regdst, b_mr, b_mw, b_m2r, b_rw, b_valid, b_stall;
   logic [1:0] b_aluop;
   logic [31:0] b_rs, b_rt, b_imm;
   logic [4:0] b_rsa, b_rta, b_rda;
   logic [1:0] b_cnt;

   int checks = 0, errors = 0;
   out_t sb[$];
   logic [110:0] last_data;
   vec_t tbl[15];
   vec_t sat[$];

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .CNT_W(16)) u_a (
      .clk_i(clk), .rst_i(rst_i), .Ctrl_i(Ctrl_i), .Flush_i(Flush_i),
      .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .Imm_i(Imm_i),
      .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
      .ALUSrc_o(a_alusrc), .ALUOp_o(a_aluop), .RegDst_o(a_regdst), .MemRead_o(a_mr),
      .MemWrite_o(a_mw), .MemtoReg_o(a_m2r), .RegWrite_o(a_rw),
      .RSdata_o(a_rs), .RTdata_o(a_rt), .Imm_o(a_imm),
      .RSaddr_o(a_rsa), .RTaddr_o(a_rta), .RDaddr_o(a_rda),
      .Valid_o(a_valid), .Stall_o(a_stall), .StallCnt_o(a_cnt));

   id_ex_stage #(.DATA_W(32), .CNT_W(2)) u_b (
      .clk_i(clk), .rst_i(rst_i), .Ctrl_i(Ctrl_i), .Flush_i(Flush_i),
      .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .Imm_i(Imm_i),
      .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
      .ALUSrc_o(b_alusrc), .ALUOp_o(b_aluop), .RegDst_o(b_regdst), .MemRead_o(b_mr),
      .MemWrite_o(b_mw), .MemtoReg_o(b_m2r), .RegWrite_o(b_rw),
      .RSdata_o(b_rs), .RTdata_o(b_rt), .Imm_o(b_imm),
      .RSaddr_o(b_rsa), .RTaddr_o(b_rta), .RDaddr_o(b_rda),
      .Valid_o(b_valid), .Stall_o(b_stall), .StallCnt_o(b_cnt));

   function automatic vec_t mk(logic [7:0] c, logic f, logic [31:0] rs, logic [31:0] rt,
                               logic [31:0] imm, logic [4:0] rsa, logic [4:0] rta,
                               logic [4:0] rda, logic st, logic va, logic [15:0] cnt);
      vec_t v;
      v.ctrl = c; v.flush = f; v.rs = rs; v.rt = rt; v.imm = imm;
      v.rsa = rsa; v.rta = rta; v.rda = rda;
      v.exp_stall = st; v.exp_valid = va; v.exp_cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step(input vec_t v);
      out_t e, g;
      @(negedge clk);
      Ctrl_i = v.ctrl; Flush_i = v.flush; RSdata_i = v.rs; RTdata_i = v.rt; Imm_i = v.imm;
      RSaddr_i = v.rsa; RTaddr_i = v.rta; RDaddr_i = v.rda;
      #1;
      check("stall", 128'(a_stall), 128'(v.exp_stall));
      check("stall_b", 128'(b_stall), 128'(v.exp_stall));
      if (v.exp_valid) last_data = {v.rs, v.rt, v.imm, v.rsa, v.rta, v.rda};
      e.ctrl = v.exp_valid ? v.ctrl : 8'd0;
      e.valid = v.exp_valid;
      e.data = last_data;
      e.cnt = v.exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check("ctrl", 128'({a_alusrc, a_aluop, a_regdst, a_mr, a_mw, a_m2r, a_rw}), 128'(g.ctrl));
      check("ctrl_b", 128'({b_alusrc, b_aluop, b_regdst, b_mr, b_mw, b_m2r, b_rw}), 128'(g.ctrl));
      check("valid", 128'(a_valid), 128'(g.valid));
      check("data", 128'({a_rs, a_rt, a_imm, a_rsa, a_rta, a_rda}), 128'(g.data));
      check("cnt16", 128'(a_cnt), 128'(g.cnt));
      check("cnt2", 128'(b_cnt), 128'((g.cnt > 16'd3) ? 16'd3 : g.cnt));
   endtask

   task automatic check_reset_state();
      check("rst_ctrl", 128'({a_alusrc, a_aluop, a_regdst, a_mr, a_mw, a_m2r, a_rw, a_valid}), 128'(0));
      check("rst_data", 128'({a_rs, a_rt, a_imm, a_rsa, a_rta, a_rda}), 128'(0));
      check("rst_cnt", 128'({a_cnt, b_cnt}), 128'(0));
      check("rst_stall", 128'({a_stall, b_stall}), 128'(0));
   endtask

   initial begin
      last_data = '0;
      #1 check_reset_state();
      #1 rst_i = 1'b1;
      tbl[0]  = mk(8'h71, 0, 32'h5,   32'h7,  0, 1,  2,  3,  0, 1, 0);
      tbl[1]  = mk(8'h8B, 0, 32'h100, 32'h0,  4, 29, 8,  0,  0, 1, 0);
      tbl[2]  = mk(8'h71, 0, 32'h11,  32'h22, 0, 8,  9,  10, 1, 0, 1);
      tbl[3]  = mk(8'h71, 0, 32'h11,  32'h22, 0, 8,  9,  10, 0, 1, 1);
      tbl[4]  = mk(8'h8B, 0, 32'h200, 32'h0,  8, 29, 0,  0,  0, 1, 1);
      tbl[5]  = mk(8'h71, 0, 32'h1,   32'h2,  0, 0,  0,  4,  0, 1, 1);
      tbl[6]  = mk(8'h8B, 0, 32'h300, 32'h0, 12, 29, 8,  0,  0, 1, 1);
      tbl[7]  = mk(8'h71, 0, 32'h3,   32'h4,  0, 9,  10, 11, 0, 1, 1);
      tbl[8]  = mk(8'h8B, 0, 32'h400, 32'h0, 16, 29, 8,  0,  0, 1, 1);
      tbl[9]  = mk(8'h71, 1, 32'h5,   32'h6,  0, 8,  9,  12, 0, 0, 1);
      tbl[10] = mk(8'h8B, 0, 32'h500, 32'h0, 20, 29, 8,  0,  0, 1, 1);
      tbl[11] = mk(8'h71, 0, 32'h7,   32'h8,  0, 1,  8,  13, 1, 0, 2);
      tbl[12] = mk(8'h71, 0, 32'h7,   32'h8,  0, 1,  8,  13, 0, 1, 2);
      tbl[13] = mk(8'h84, 0, 32'h600, 32'h66, 24, 29, 8, 0,  0, 1, 2);
      tbl[14] = mk(8'h71, 0, 32'h9,   32'hA,  0, 8,  1,  14, 0, 1, 2);
      @(posedge clk);
      for (int i = 0; i < 15; i++) step(tbl[i]);
      // Asynchronous reset pulse between edges with random inputs.
      #2;
      Ctrl_i = 8'($urandom); RSdata_i = $urandom; RTdata_i = $urandom; Imm_i = $urandom;
      RSaddr_i = 5'($urandom); RTaddr_i = 5'($urandom); RDaddr_i = 5'($urandom);
      rst_i = 1'b0;
      #1 check_reset_state();
      rst_i = 1'b1;
      last_data = '0;
      for (int k = 1; k <= 5; k++) begin
         sat.push_back(mk(8'h8B, 0, 32'h700 + k, 0, 32'(k), 29, 8, 0, 0, 1, 16'(k - 1)));
         sat.push_back(mk(8'h71, 0, 32'(k), 32'h2, 0, 8, 3, 5, 1, 0, 16'(k)));
         sat.push_back(mk(8'h71, 0, 32'(k), 32'h2, 0, 8, 3, 5, 0, 1, 16'(k)));
      end
      foreach (sat[i]) step(sat[i]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
